spi_reg_bank: RTL

// - Parametrised SPI (mode 0) peripheral fronting a bank of NUM_REGS x DATA_W control registers.
// - Successor to the fixed 5 x 8-bit write-only SPI register block.
// - Adds generic width and depth, read-back over CIPO, a write-commit strobe and a framing-error counter.
// - Sits between the chip pads and the output/PWM configuration logic.

---
 rtl/spi_reg_bank.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - SPI mode-0 peripheral fronting a NUM_REGS x DATA_W register bank.
// Optional CIPO read-back is enabled by defining SPI_REG_READBACK_EN.
module spi_reg_bank #(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       nCS,
  input  logic                       SCLK,
  input  logic                       COPI,
  output logic                       CIPO,
  output logic                       CIPO_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic                       wr_valid,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [7:0]                 err_cnt
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CW      = $clog2(FRAME_W + 2);
  localparam logic [CW-1:0]   CNT_FULL = CW'(FRAME_W);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(FRAME_W + 1);
  localparam logic [ADDR_W:0] NREGS    = (ADDR_W + 1)'(NUM_REGS);

  logic [SYNC_STAGES-1:0]     ncs_sync, sclk_sync, copi_sync;
  logic                       prev_ncs, prev_sclk;
  logic [FRAME_W-1:0]         shreg;
  logic [CW-1:0]              cnt;
  logic [NUM_REGS*DATA_W-1:0] regs_q;

  logic s_ncs, s_sclk, s_copi;
  logic sclk_rise, ncs_rise, ncs_fall, shift_en;
  logic f_rw, addr_ok, frame_full, commit, reject;
  logic [ADDR_W-1:0]  f_addr;
  logic [DATA_W-1:0]  f_data;
  logic [FRAME_W-1:0] sh_next;

  assign s_ncs  = ncs_sync[SYNC_STAGES-1];
  assign s_sclk = sclk_sync[SYNC_STAGES-1];
  assign s_copi = copi_sync[SYNC_STAGES-1];

  assign sclk_rise = s_sclk & ~prev_sclk;
  assign ncs_rise  = s_ncs & ~prev_ncs;
  assign ncs_fall  = ~s_ncs & prev_ncs;
  // An SCLK edge coinciding with nCS rising is dropped; s_ncs is already high then.
  assign shift_en  = sclk_rise & ~s_ncs;
  assign sh_next   = {shreg[FRAME_W-2:0], s_copi};

  assign f_rw       = shreg[FRAME_W-1];
  assign f_addr     = shreg[DATA_W +: ADDR_W];
  assign f_data     = shreg[DATA_W-1:0];
  assign addr_ok    = {1'b0, f_addr} < NREGS;
  assign frame_full = (cnt == CNT_FULL);
  assign commit     = ncs_rise & frame_full & f_rw & addr_ok;
  assign reject     = ncs_rise & (~frame_full | (f_rw & ~addr_ok));

  assign regs_o = regs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ncs_sync  <= '1;
      sclk_sync <= '0;
      copi_sync <= '0;
      prev_ncs  <= 1'b1;
      prev_sclk <= 1'b0;
    end else begin
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], nCS};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], COPI};
      prev_ncs  <= s_ncs;
      prev_sclk <= s_sclk;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      cnt      <= '0;
      regs_q   <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      err_cnt  <= '0;
    end else begin
      wr_valid <= 1'b0;
      if (ncs_fall) begin
        shreg <= '0;
        cnt   <= '0;
      end else if (shift_en) begin
        shreg <= sh_next;
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end
      // Commit reads the frame captured so far; a same-cycle nCS fall only resets the shifter.
      if (commit) begin
        for (int i = 0; i < NUM_REGS; i++)
          if (f_addr == ADDR_W'(i)) regs_q[i*DATA_W +: DATA_W] <= f_data;
        wr_valid <= 1'b1;
        wr_addr  <= f_addr;
      end
      if (reject && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

`ifdef SPI_REG_READBACK_EN
  logic              sclk_fall, addr_done, tx_active, cipo_q;
  logic [DATA_W-1:0] tx, rd_word;

  assign sclk_fall = ~s_sclk & prev_sclk;
  assign addr_done = shift_en & (cnt == CW'(ADDR_W)) & ~sh_next[ADDR_W];

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (sh_next[ADDR_W-1:0] == ADDR_W'(i)) rd_word = regs_q[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx        <= '0;
      tx_active <= 1'b0;
      cipo_q    <= 1'b0;
    end else if (ncs_fall || ncs_rise) begin
      tx        <= '0;
      tx_active <= 1'b0;
      cipo_q    <= 1'b0;
    end else if (addr_done) begin
      tx        <= rd_word;
      tx_active <= 1'b1;
    end else if (shift_en && cnt >= CW'(FRAME_W - 1)) begin
      // Host has already sampled the last data bit by the time this edge is seen.
      tx_active <= 1'b0;
      cipo_q    <= 1'b0;
    end else if (sclk_fall && !s_ncs && tx_active) begin
      cipo_q <= tx[DATA_W-1];
      tx     <= tx << 1;
    end
  end

  assign CIPO    = cipo_q;
  assign CIPO_oe = ~s_ncs;
`else
  assign CIPO    = 1'b0;
  assign CIPO_oe = 1'b0;
`endif

endmodule
